// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler sharing one serial run-of-four detector among N requesters.
// Each granted word is shifted LSB-first into the detector and one hit/no-hit result is reported per frame.
module run_detect_scheduler #(
    parameter int N   = 4,
    parameter int LEN = 8
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [N-1:0]         req,
    input  logic [N*LEN-1:0]     data,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 hit,
    output logic [$clog2(N)-1:0] ch,
    output logic                 det_w,
    output logic                 det_clr,
    input  logic                 det_z
);

    localparam int CHW = $clog2(N);
    localparam int CW  = $clog2(LEN);
    localparam int SW  = CHW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t           state;
    state_t           next;
    logic [LEN-1:0]   sreg;
    logic [CW-1:0]    cnt;
    logic             acc;
    logic [CHW-1:0]   last;
    logic [CHW-1:0]   start;
    logic [CHW-1:0]   off;
    logic [CHW-1:0]   pick;
    logic [SW-1:0]    sum;
    logic [2*N-1:0]   rot;
    logic [LEN-1:0]   word;
    logic             last_bit;

    assign last_bit = (cnt == CW'(LEN - 1));

    // Arbitration: rotate requests so the channel after the last served sits at bit 0.
    always_comb begin
        start = (last == CHW'(N - 1)) ? '0 : last + 1'b1;
        rot   = {req, req} >> start;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = CHW'(k);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= SW'(N)) sum = sum - SW'(N);
        pick = sum[CHW-1:0];
        word = '0;
        for (int k = 0; k < N; k++) begin
            if (pick == CHW'(k)) word = data[k*LEN +: LEN];
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next    = state;
        busy    = 1'b1;
        done    = 1'b0;
        det_clr = 1'b1;
        det_w   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req) next = CLEAR;
            end
            CLEAR: next = SHIFT;
            SHIFT: begin
                det_clr = 1'b0;
                det_w   = sreg[0];
                if (last_bit) next = DRAIN;
            end
            DRAIN: begin
                det_clr = 1'b0;
                det_w   = sreg[0];
                next    = REPORT;
            end
            REPORT: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Control registers: grant, channel index, arbitration pointer and the reported result.
    always_ff @(posedge clk) begin
        if (aclr) begin
            gnt  <= '0;
            ch   <= '0;
            last <= CHW'(N - 1);
            hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt <= N'(1) << pick;
                        ch  <= pick;
                    end
                end
                DRAIN: hit <= acc | det_z;
                REPORT: begin
                    gnt  <= '0;
                    last <= ch;
                end
                default: ;
            endcase
        end
    end

    // Datapath: the last bit is not shifted out so it stays on det_w through DRAIN.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (|req) sreg <= word;
            end
            CLEAR: begin
                cnt <= '0;
                acc <= 1'b0;
            end
            SHIFT: begin
                acc <= acc | det_z;
                if (!last_bit) begin
                    cnt  <= cnt + 1'b1;
                    sreg <= sreg >> 1;
                end
            end
            DRAIN: acc <= acc | det_z;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Scoreboard bench for run_detect_scheduler with a behavioural run-of-four detector on the det_* pins.
// Expected (channel, hit) pairs are queued when a frame is launched and popped on each done pulse.
module tb_run_detect_scheduler;

    localparam int N   = 4;
    localparam int LEN = 8;

    logic                 clk = 1'b0;
    logic                 aclr;
    logic [N-1:0]         req;
    logic [N*LEN-1:0]     data;
    logic [N-1:0]         gnt;
    logic                 busy;
    logic                 done;
    logic                 hit;
    logic [$clog2(N)-1:0] ch;
    logic                 det_w;
    logic                 det_clr;
    logic                 det_z;

    typedef struct {
        int   c;
        logic h;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_hit = 1'b0;
    int   cyc = 0;

    run_detect_scheduler #(.N(N), .LEN(LEN)) dut (
        .clk     (clk),
        .aclr    (aclr),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .hit     (hit),
        .ch      (ch),
        .det_w   (det_w),
        .det_clr (det_clr),
        .det_z   (det_z)
    );

    always #5 clk = ~clk;

    // Behavioural Moore detector: z=1 once the current run of equal bits reaches four.
    logic [2:0] run_len = 3'd0;
    logic       prev_w  = 1'b0;
    always @(posedge clk) begin
        if (det_clr) begin
            run_len <= 3'd0;
        end else begin
            if (run_len == 3'd0 || det_w != prev_w) run_len <= 3'd1;
            else if (run_len < 3'd4)                run_len <= run_len + 3'd1;
            prev_w <= det_w;
        end
    end
    assign det_z = (run_len >= 3'd4);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic model_hit(input logic [LEN-1:0] w);
        int   run = 1;
        logic h   = 1'b0;
        for (int i = 1; i < LEN; i++) begin
            if (w[i] == w[i-1]) run++;
            else                run = 1;
            if (run >= 4) h = 1'b1;
        end
        return h;
    endfunction

    // Scoreboard monitor and per-cycle grant invariants.
    always @(negedge clk) begin
        if (!aclr) begin
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (busy) chk("gnt_matches_ch", 32'(gnt), 32'(1) << ch);
            if (done) begin
                chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_ch", 32'(ch), 32'(e.c));
                    chk("sb_hit", 32'(hit), 32'(e.h));
                    prev_hit = e.h;
                end
            end
        end
    end

    task automatic frame(input logic [N-1:0] r, input int c, input logic [LEN-1:0] w, input bit drop_late);
        int   n;
        logic eh;
        eh = model_hit(w);
        data[c*LEN +: LEN] = w;
        exp_q.push_back('{c: c, h: eh});
        req = r;
        @(posedge clk); #1;
        if (!drop_late) req = '0;
        @(negedge clk);
        chk("c1_gnt", 32'(gnt), 32'(1) << c);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_clr", 32'(det_clr), 32'd1);
        @(posedge clk); #1;
        if (drop_late) begin
            req = '0;
            data[c*LEN +: LEN] = ~w;
        end
        @(negedge clk);
        chk("c2_clr", 32'(det_clr), 32'd0);
        chk("c2_w", 32'(det_w), 32'(w[0]));
        chk("hit_held", 32'(hit), 32'(prev_hit));
        n = 2;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("done_cycle", 32'(n), 32'(LEN + 3));
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_hit", 32'(hit), 32'(eh));
    endtask

    initial begin
        int done_cyc[4];
        int nd;
        int t;

        aclr = 1'b1;
        req  = '0;
        data = '0;
        repeat (2) @(posedge clk);
        #1 aclr = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_ch", 32'(ch), 32'd0);
        chk("rst_clr", 32'(det_clr), 32'd1);
        chk("rst_w", 32'(det_w), 32'd0);
        @(posedge clk); #1;

        frame(4'b0001, 0, 8'h0F, 1'b0);
        frame(4'b0001, 0, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("hit_stays0", 32'(hit), 32'd0);
        frame(4'b0001, 0, 8'hE7, 1'b0);
        frame(4'b0001, 0, 8'hF0, 1'b0);
        frame(4'b0001, 0, 8'h0F, 1'b1);

        // Constant req=1010 from reset: expect ch 1,3,1,3 every 12 cycles.
        aclr = 1'b1;
        req  = 4'b1010;
        data = '0;
        data[1*LEN +: LEN] = 8'h0F;
        data[3*LEN +: LEN] = 8'h55;
        exp_q.push_back('{c: 1, h: model_hit(8'h0F)});
        exp_q.push_back('{c: 3, h: model_hit(8'h55)});
        exp_q.push_back('{c: 1, h: model_hit(8'h0F)});
        exp_q.push_back('{c: 3, h: model_hit(8'h55)});
        @(posedge clk); #1 aclr = 1'b0;
        prev_hit = 1'b0;
        nd = 0;
        t  = 0;
        while (nd < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (done) begin
                done_cyc[nd] = t;
                nd++;
                if (nd == 4) req = '0;
            end
        end
        chk("rr_done_count", 32'(nd), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < nd) chk("rr_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd12);
        end
        repeat (3) @(posedge clk);
        #1 chk("rr_idle", 32'(busy), 32'd0);

        // Reset in SHIFT cycle 5 aborts the frame without a done pulse.
        data[0 +: LEN] = 8'h0F;
        req = 4'b0001;
        @(posedge clk); #1 req = '0;
        repeat (4) @(posedge clk);
        #1 aclr = 1'b1;
        @(posedge clk); #1 aclr = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_clr", 32'(det_clr), 32'd1);
        chk("abort_w", 32'(det_w), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hit", 32'(hit), 32'd0);
        chk("abort_ch", 32'(ch), 32'd0);
        prev_hit = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        frame(4'b0100, 2, 8'hF0, 1'b0);

        repeat (3) @(posedge clk);
        chk("q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d exp finished", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
